ring_phase_monitor: RTL and testbench
=====================================

// Module: ring_phase_monitor
// PURPOSE
//  Downstream consumer and supervisor of the 4-bit one-hot rotating ring register.
//  Issues the ring load pulse and checks the rotation every cycle.
//  Decodes the active bit into a phase index and counts full revolutions.
//  Detects corruption, reloads the ring, and latches a sticky fault on repeated failure.
// PARAMETERS
//  WIDTH       4  ring width (number of one-hot bits)
//  REV_CNT_W   8  revolution counter width; wraps modulo 2^REV_CNT_W
//  ERR_CNT_W   8  error counter width; saturates at all-ones
//  ERR_THRESH  2  consecutive failed resyncs that latch fault
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous, active-high reset
//  start        in   1               begin supervision (honoured in IDLE only)
//  stop         in   1               return to IDLE from any state except FAULT
//  clear_fault  in   1               FAULT -> IDLE
//  ring_in      in   WIDTH           current ring register value
//  ring_ld      out  1               load request to ring (ring loads 1<<(WIDTH-1))
//  phase_idx    out  $clog2(WIDTH)   index of the active ring bit
//  phase_valid  out  1               phase_idx holds a checked value
//  rev_tick     out  1               1-cycle pulse per completed revolution
//  rev_count    out  REV_CNT_W       revolution count
//  err          out  1               1-cycle pulse on rotation/sync mismatch
//  err_count    out  ERR_CNT_W       total mismatches (saturating)
//  fault        out  1               sticky fault flag
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; all outputs 0; prev, consec_err = 0.
//  Ring model: with ld=0 the ring rotates every cycle: next = {cur[WIDTH-2:0], cur[WIDTH-1]};
//   HOME = 1<<(WIDTH-1). Sequence for WIDTH=4: 1000, 0001, 0010, 0100, 1000.
//  All outputs are registered. Checks in cycle c appear at cycle c+1.
//  FSM:
//   IDLE: ring_ld=0, phase_valid=0. start & !stop -> LOAD.
//   LOAD: ring_ld=1 for exactly this cycle -> SYNC.
//   SYNC: ring_in==HOME -> TRACK (prev<=ring_in, phase_valid=1);
//         otherwise err pulse, err_count++, consec_err++ -> RECOVER.
//   TRACK: ring_in==rotl(prev) -> prev<=ring_in, phase_idx<=onehot index.
//          If ring_in==HOME: rev_tick=1, rev_count++, consec_err<=0.
//          On mismatch: err pulse, err_count++, consec_err++, phase_valid<=0 -> RECOVER.
//   RECOVER: if consec_err>=ERR_THRESH -> FAULT; else ring_ld=1 this cycle -> SYNC.
//   FAULT: fault=1, ring_ld=0, phase_valid=0; start ignored; clear_fault -> IDLE
//          (fault<=0, consec_err<=0; counters keep their values).
//  stop has priority over start and over any transition; in TRACK, SYNC, LOAD or RECOVER
//   it forces IDLE next cycle and clears phase_valid. A pending ring_ld is not issued.
//  Entering TRACK from SYNC does not count as a revolution.
//  Invalid patterns (zero bits or more than one bit set) always mismatch.
//  rev_count wraps (all-ones -> 0). err_count holds at all-ones.
//  rst has priority over everything, including mid-LOAD: ring_ld drops the next cycle.
// STRUCTURE
//  Shared package ring_mon_pkg:
//   - state enum/localparams: IDLE, LOAD, SYNC, TRACK, RECOVER, FAULT
//   - function rotl(WIDTH)
//   - function onehot_idx
//  Sub-module ring_onehot_check (combinational): ring_in, prev ->
//   is_onehot, is_home, matches_rotl, idx.
//  Top level holds the FSM, counters and output registers.
// TESTING (WIDTH=4, ERR_THRESH=2, behavioural ring model driven by ring_ld)
//  1. rst, then start for 1 cycle -> ring_ld high for 1 cycle.
//     Ring 1000,0001,0010,0100,1000 -> phase_idx 3,0,1,2,3.
//     rev_tick once, rev_count=1, err never asserted.
//  2. In TRACK, force ring_in=0011 instead of 0010 -> err 1 cycle, err_count=1,
//     phase_valid=0, ring_ld pulse, resync to 1000, TRACK resumes.
//  3. Ring held at 0000 (ignores ld) -> two SYNC failures -> fault=1, ring_ld stays 0.
//     start ignored; clear_fault -> IDLE with fault=0, err_count=2.
//  4. rst asserted mid-TRACK (rev_count=5) -> next cycle all outputs 0, state IDLE.
//  5. start and stop together in IDLE -> stays IDLE, no ring_ld.
//     stop in TRACK -> IDLE, phase_valid=0.
//  6. Run 256 revolutions with REV_CNT_W=8 -> rev_count wraps 255 -> 0 with a rev_tick on the wrap.

Source files
------------

// File: rtl/ring_mon_pkg.sv
// ---------------------------------------------------------------------------
// ring_mon_pkg
//   Shared definitions for the one-hot ring supervisor.
//   - state_t      : supervisor FSM states
//   - MAX_WIDTH    : widest ring the helper functions can handle
//   - home_pattern : HOME value (MSB set) for a given ring width
//   - rotl         : one-position left rotation inside a ring of given width
//   - onehot_idx   : bit index of the set bit in a one-hot value
// The helpers take the ring width as an argument and operate on MAX_WIDTH-wide
// vectors. Callers zero-extend their ring values and truncate the results.
// ---------------------------------------------------------------------------
package ring_mon_pkg;

    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC,
        TRACK,
        RECOVER,
        FAULT
    } state_t;

    // Value the ring takes when loaded: only the top bit of the ring set.
    function automatic logic [MAX_WIDTH-1:0] home_pattern(input int unsigned width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

    // Rotate left by one inside a ring of 'width' bits; bits above the ring
    // are masked off so the MSB wraps into bit 0.
    function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] v,
                                                  input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        end
        return ((v << 1) | (v >> (width - 1))) & mask;
    endfunction

    // Index of the set bit. Only meaningful for one-hot inputs; for other
    // patterns the highest set bit wins (callers gate the result anyway).
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_WIDTH-1:0] v);
        logic [MAX_WIDTH-1:0] shifted;
        logic [IDX_W-1:0]     idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            shifted = v >> i;
            if (shifted[0]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// ---------------------------------------------------------------------------
// ring_onehot_check
//   Purely combinational pattern checker for the supervised ring.
//   Ports:
//     ring_in      in   WIDTH          current ring register value
//     prev         in   WIDTH          last value accepted by the supervisor
//     is_onehot    out  1              exactly one bit of ring_in set
//     is_home      out  1              ring_in equals HOME (MSB only)
//     matches_rotl out  1              ring_in is one-hot and equals rotl(prev)
//     idx          out  $clog2(WIDTH)  index of the set bit of ring_in
// ---------------------------------------------------------------------------
module ring_onehot_check
    import ring_mon_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]         ring_in,
    input  logic [WIDTH-1:0]         prev,
    output logic                     is_onehot,
    output logic                     is_home,
    output logic                     matches_rotl,
    output logic [$clog2(WIDTH)-1:0] idx
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] HOME = WIDTH'(home_pattern(WIDTH));

    logic [WIDTH-1:0] expected;

    always_comb begin
        expected     = WIDTH'(rotl(MAX_WIDTH'(prev), WIDTH));
        is_onehot    = $onehot(ring_in);
        is_home      = (ring_in == HOME);
        // Qualify with is_onehot so a corrupted prev can never make an
        // invalid pattern look like a legal step.
        matches_rotl = is_onehot && (ring_in == expected);
        idx          = IW'(onehot_idx(MAX_WIDTH'(ring_in)));
    end

endmodule

// File: rtl/ring_phase_monitor.sv
// ---------------------------------------------------------------------------
// ring_phase_monitor
//   Supervisor for a WIDTH-bit one-hot rotating ring register. Requests the
//   ring load, follows the rotation every cycle, reports the phase index,
//   counts revolutions, and on corruption reloads the ring. Too many
//   consecutive failed resyncs latch a sticky fault.
//   All outputs are registered: a check made in cycle c is visible in c+1.
//   Ports:
//     clk          in   1               clock, rising edge
//     rst          in   1               synchronous, active-high reset
//     start        in   1               begin supervision (IDLE only)
//     stop         in   1               back to IDLE from any state but FAULT
//     clear_fault  in   1               FAULT -> IDLE
//     ring_in      in   WIDTH           current ring register value
//     ring_ld      out  1               ring load request (ring loads HOME)
//     phase_idx    out  $clog2(WIDTH)   index of the active ring bit
//     phase_valid  out  1               phase_idx holds a checked value
//     rev_tick     out  1               pulse per completed revolution
//     rev_count    out  REV_CNT_W       revolution count (wraps)
//     err          out  1               pulse on rotation/sync mismatch
//     err_count    out  ERR_CNT_W       total mismatches (saturating)
//     fault        out  1               sticky fault flag
// ---------------------------------------------------------------------------
module ring_phase_monitor
    import ring_mon_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned REV_CNT_W  = 8,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned ERR_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     clear_fault,
    input  logic [WIDTH-1:0]         ring_in,
    output logic                     ring_ld,
    output logic [$clog2(WIDTH)-1:0] phase_idx,
    output logic                     phase_valid,
    output logic                     rev_tick,
    output logic [REV_CNT_W-1:0]     rev_count,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic                     fault
);

    localparam int unsigned IW = $clog2(WIDTH);
    // One spare bit so the threshold itself is always representable.
    localparam int unsigned CW = $clog2(ERR_THRESH + 1) + 1;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    consec_err;

    logic             is_onehot;
    logic             is_home;
    logic             matches_rotl;
    logic [IW-1:0]    idx;

    logic [CW-1:0]        consec_inc;
    logic [ERR_CNT_W-1:0] err_count_inc;
    logic                 retry_ld;

    ring_onehot_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .ring_in      (ring_in),
        .prev         (prev),
        .is_onehot    (is_onehot),
        .is_home      (is_home),
        .matches_rotl (matches_rotl),
        .idx          (idx)
    );

    always_comb begin
        consec_inc    = (consec_err == '1) ? consec_err : consec_err + CW'(1);
        err_count_inc = (err_count == '1) ? err_count : err_count + ERR_CNT_W'(1);
        // ring_ld is a registered output, so the reload for RECOVER has to be
        // decided on the way in, from the failure count RECOVER will see.
        retry_ld      = (consec_inc < CW'(ERR_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prev        <= '0;
            consec_err  <= '0;
            ring_ld     <= 1'b0;
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            rev_tick    <= 1'b0;
            rev_count   <= '0;
            err         <= 1'b0;
            err_count   <= '0;
            fault       <= 1'b0;
        end else begin
            // Pulsed outputs default low every cycle.
            ring_ld  <= 1'b0;
            rev_tick <= 1'b0;
            err      <= 1'b0;

            if (stop && (state != FAULT)) begin
                // stop overrides every transition; any pending load is dropped.
                state       <= IDLE;
                phase_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        phase_valid <= 1'b0;
                        if (start) begin
                            state   <= LOAD;
                            ring_ld <= 1'b1;
                        end
                    end

                    LOAD: begin
                        state <= SYNC;
                    end

                    SYNC: begin
                        if (is_onehot && is_home) begin
                            state       <= TRACK;
                            prev        <= ring_in;
                            phase_idx   <= idx;
                            phase_valid <= 1'b1;
                        end else begin
                            state      <= RECOVER;
                            err        <= 1'b1;
                            err_count  <= err_count_inc;
                            consec_err <= consec_inc;
                            ring_ld    <= retry_ld;
                        end
                    end

                    TRACK: begin
                        if (matches_rotl) begin
                            prev      <= ring_in;
                            phase_idx <= idx;
                            // The SYNC entry is not a revolution; only a
                            // checked step back onto HOME is.
                            if (is_home) begin
                                rev_tick   <= 1'b1;
                                rev_count  <= rev_count + REV_CNT_W'(1);
                                consec_err <= '0;
                            end
                        end else begin
                            state       <= RECOVER;
                            phase_valid <= 1'b0;
                            err         <= 1'b1;
                            err_count   <= err_count_inc;
                            consec_err  <= consec_inc;
                            ring_ld     <= retry_ld;
                        end
                    end

                    RECOVER: begin
                        if (consec_err >= CW'(ERR_THRESH)) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end

                    FAULT: begin
                        phase_valid <= 1'b0;
                        if (clear_fault) begin
                            state      <= IDLE;
                            fault      <= 1'b0;
                            consec_err <= '0;
                        end
                    end

                    default: begin
                        state       <= IDLE;
                        phase_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// ---------------------------------------------------------------------------
// tb_ring_phase_monitor
//   Self-checking bench for ring_phase_monitor (WIDTH=4, ERR_THRESH=2).
//   A behavioural ring register follows ring_ld; expected outputs come from
//   counting cycles since the last successful sync.
// ---------------------------------------------------------------------------
module tb_ring_phase_monitor;

    localparam int unsigned WIDTH      = 4;
    localparam int unsigned REV_CNT_W  = 8;
    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned ERR_THRESH = 2;
    localparam int          REV_MOD    = 1 << REV_CNT_W;
    localparam logic [WIDTH-1:0] HOME  = 4'b1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             clear_fault;
    logic [WIDTH-1:0] ring_in;
    logic             ring_ld;
    logic [1:0]       phase_idx;
    logic             phase_valid;
    logic             rev_tick;
    logic [7:0]       rev_count;
    logic             err;
    logic [7:0]       err_count;
    logic             fault;

    ring_phase_monitor #(
        .WIDTH      (WIDTH),
        .REV_CNT_W  (REV_CNT_W),
        .ERR_CNT_W  (ERR_CNT_W),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .clear_fault (clear_fault),
        .ring_in     (ring_in),
        .ring_ld     (ring_ld),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .rev_tick    (rev_tick),
        .rev_count   (rev_count),
        .err         (err),
        .err_count   (err_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Behavioural ring: loads HOME on ring_ld, otherwise rotates left.
    logic [WIDTH-1:0] ring_reg = 4'b0000;
    logic             stuck;
    logic             force_en;
    logic [WIDTH-1:0] force_val;

    always @(posedge clk) begin
        if (ring_ld) ring_reg <= HOME;
        else         ring_reg <= {ring_reg[WIDTH-2:0], ring_reg[WIDTH-1]};
    end

    assign ring_in = stuck ? 4'b0000 : (force_en ? force_val : ring_reg);

    // Reference state: counts derived from the observed history.
    int checks      = 0;
    int errors      = 0;
    int steps       = 0;   // cycles since the supervisor last synced on HOME
    int exp_rev     = 0;
    int exp_err     = 0;
    int consec_fail = 0;   // failures since the last completed revolution
    int extra;
    logic [WIDTH-1:0] bad;
    logic [WIDTH-1:0] good;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ld"}, ring_ld, 0);
        chk({tag, "_idx"}, phase_idx, 0);
        chk({tag, "_pv"}, phase_valid, 0);
        chk({tag, "_tick"}, rev_tick, 0);
        chk({tag, "_rev"}, rev_count, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_errcnt"}, err_count, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rev     = 0;
        exp_err     = 0;
        consec_fail = 0;
        chk_reset_outs("reset");
    endtask

    // From IDLE with a healthy ring: one load pulse, then sync on HOME.
    task automatic start_and_sync();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ld", ring_ld, 1);
        tick();
        chk("sync_ld", ring_ld, 0);
        chk("sync_pv", phase_valid, 0);
        tick();
        steps = 0;
        chk("synced_pv", phase_valid, 1);
        chk("synced_idx", phase_idx, WIDTH - 1);
        chk("synced_tick", rev_tick, 0);
        chk("synced_rev", rev_count, exp_rev);
    endtask

    task automatic track(input int n);
        logic exp_tick;
        for (int i = 0; i < n; i++) begin
            tick();
            steps++;
            exp_tick = (steps % WIDTH == 0);
            if (exp_tick) begin
                exp_rev     = (exp_rev + 1) % REV_MOD;
                consec_fail = 0;
            end
            chk("track_idx", phase_idx, (WIDTH - 1 + steps) % WIDTH);
            chk("track_pv", phase_valid, 1);
            chk("track_tick", rev_tick, exp_tick);
            chk("track_rev", rev_count, exp_rev);
            chk("track_err", err, 0);
            chk("track_ld", ring_ld, 0);
        end
    endtask

    // Replace the next ring value with 'pat' for one cycle, then follow the
    // reload and resync.
    task automatic corrupt(input logic [WIDTH-1:0] pat);
        force_en  = 1'b1;
        force_val = pat;
        tick();
        force_en = 1'b0;
        consec_fail++;
        if (exp_err < (1 << ERR_CNT_W) - 1) exp_err++;
        chk("corrupt_err", err, 1);
        chk("corrupt_errcnt", err_count, exp_err);
        chk("corrupt_pv", phase_valid, 0);
        chk("corrupt_ld", ring_ld, consec_fail < ERR_THRESH);
        tick();
        chk("recover_err", err, 0);
        chk("recover_ld", ring_ld, 0);
        tick();
        steps = 0;
        chk("resync_pv", phase_valid, 1);
        chk("resync_idx", phase_idx, WIDTH - 1);
        chk("resync_fault", fault, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        clear_fault = 1'b0;
        stuck       = 1'b0;
        force_en    = 1'b0;
        force_val   = '0;
        tick();

        // 1: reset, start, one clean revolution.
        do_reset();
        start_and_sync();
        track(WIDTH);
        chk("one_rev_count", rev_count, 1);
        chk("one_rev_errcnt", err_count, 0);
        extra = $urandom_range(0, 6);
        track(extra);

        // 2: corruption in TRACK, first the 0011 case, then random patterns.
        good = 4'(1 << (steps % WIDTH));
        if (good == 4'b0010) corrupt(4'b0011);
        else                 corrupt(4'b0011 ^ 4'b0010 ^ good);
        for (int r = 0; r < 3; r++) begin
            extra = WIDTH + $urandom_range(0, 6);
            track(extra);
            good = 4'(1 << (steps % WIDTH));
            do begin
                bad = 4'($urandom_range(0, 15));
            end while (bad == good);
            corrupt(bad);
        end
        track(WIDTH);
        chk("after_corrupt_errcnt", err_count, exp_err);

        // 4: reset mid-TRACK once five revolutions have been counted.
        while (exp_rev != 5) track(1);
        track($urandom_range(1, WIDTH - 1));
        chk("pre_rst_rev", rev_count, 5);
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_load_ld", ring_ld, 1);
        do_reset();

        // 3: ring stuck at zero; repeated sync failures latch the fault.
        stuck = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stuck_load_ld", ring_ld, 1);
        tick();
        for (int a = 0; a < ERR_THRESH; a++) begin
            tick();
            consec_fail++;
            exp_err++;
            chk("stuck_err", err, 1);
            chk("stuck_errcnt", err_count, exp_err);
            chk("stuck_ld", ring_ld, consec_fail < ERR_THRESH);
            tick();
            chk("stuck_recover_ld", ring_ld, 0);
            chk("stuck_fault", fault, consec_fail >= ERR_THRESH);
        end
        start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("fault_hold", fault, 1);
            chk("fault_ld", ring_ld, 0);
            chk("fault_pv", phase_valid, 0);
        end
        start       = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        consec_fail = 0;
        chk("clear_fault", fault, 0);
        chk("clear_errcnt", err_count, 2);
        tick();
        chk("clear_idle_ld", ring_ld, 0);
        stuck = 1'b0;

        // 5: start+stop in IDLE, stop in TRACK, stop during LOAD.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("startstop_ld", ring_ld, 0);
        tick();
        chk("startstop_ld2", ring_ld, 0);
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chk("startstop_ld3", ring_ld, 0);
        start_and_sync();
        track(WIDTH + 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_track_pv", phase_valid, 0);
        chk("stop_track_ld", ring_ld, 0);
        chk("stop_track_rev", rev_count, exp_rev);
        tick();
        chk("stop_idle_pv", phase_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stop_load_ld1", ring_ld, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_load_ld0", ring_ld, 0);
        tick();
        tick();
        chk("stop_load_pv", phase_valid, 0);
        chk("stop_load_ld", ring_ld, 0);

        // 6: 256 revolutions wrap the revolution counter back to zero.
        do_reset();
        start_and_sync();
        track(REV_MOD * WIDTH);
        chk("wrap_rev", rev_count, 0);
        chk("wrap_tick", rev_tick, 1);
        chk("wrap_errcnt", err_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
